// File: rtl/lcd_cls_cmd_serializer.sv
// PMOD CLS command serializer: turns clear/line-write strobes into escape/ASCII byte streams.
// Optional LCD_CLS_TEXT_SANITIZE_EN replaces non-printable text chars with spaces.
module lcd_cls_cmd_serializer (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_wr_clear_display,
  input  logic         i_wr_text_line1,
  input  logic         i_wr_text_line2,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  output logic         o_command_ready,
  output logic [7:0]   o_tx_byte,
  output logic         o_tx_valid,
  input  logic         i_tx_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_CLEAR,
    ST_SEND_LINE1,
    ST_SEND_LINE2
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [127:0] snap_q, snap_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic         tx_valid_q, tx_valid_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic [4:0]   last_idx;

  function automatic logic [7:0] text_char(input logic [7:0] c);
`ifdef LCD_CLS_TEXT_SANITIZE_EN
    return ((c < 8'h20) || (c > 8'h7E)) ? 8'h20 : c;
`else
    return c;
`endif
  endfunction

  function automatic logic [7:0] seq_byte(input state_t st, input logic [4:0] idx,
                                          input logic [127:0] txt);
    logic [3:0] c;
    logic [6:0] off;
    logic [7:0] b;
    c   = 4'(idx - 5'd6);
    off = {4'd15 - c, 3'b000};
    case (idx)
      5'd0:    b = 8'h1B;
      5'd1:    b = 8'h5B;
      5'd2:    b = (st == ST_SEND_CLEAR) ? 8'h6A : ((st == ST_SEND_LINE1) ? 8'h30 : 8'h31);
      5'd3:    b = 8'h3B;
      5'd4:    b = 8'h30;
      5'd5:    b = 8'h48;
      default: b = text_char(txt[off +: 8]);
    endcase
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    last_idx   = (state_q == ST_SEND_CLEAR) ? 5'd2 : 5'd21;
    if (i_ce_2_5mhz) begin
      if (state_q == ST_IDLE) begin
        // Fixed priority; losing requests are simply not acknowledged.
        if (i_wr_clear_display) begin
          state_d    = ST_SEND_CLEAR;
          idx_d      = 5'd0;
          tx_byte_d  = 8'h1B;
          tx_valid_d = 1'b1;
        end else if (i_wr_text_line1) begin
          state_d    = ST_SEND_LINE1;
          snap_d     = i_dat_ascii_line1;
          idx_d      = 5'd0;
          tx_byte_d  = 8'h1B;
          tx_valid_d = 1'b1;
        end else if (i_wr_text_line2) begin
          state_d    = ST_SEND_LINE2;
          snap_d     = i_dat_ascii_line2;
          idx_d      = 5'd0;
          tx_byte_d  = 8'h1B;
          tx_valid_d = 1'b1;
        end
      end else if (tx_valid_q && i_tx_ready) begin
        if (idx_q == last_idx) begin
          state_d    = ST_IDLE;
          idx_d      = 5'd0;
          tx_byte_d  = 8'h00;
          tx_valid_d = 1'b0;
        end else begin
          idx_d     = idx_q + 5'd1;
          tx_byte_d = seq_byte(state_q, idx_q + 5'd1, snap_q);
        end
      end
    end
    // Tracks the next state every clock so ready rises right after reset release.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q     <= ST_IDLE;
      idx_q       <= 5'd0;
      snap_q      <= 128'd0;
      tx_byte_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign o_command_ready = cmd_ready_q;
  assign o_tx_byte       = tx_byte_q;
  assign o_tx_valid      = tx_valid_q;

endmodule
